// File: rtl/credit_rx_buffer_if.sv
// ---------------------------------------------------------------------------
// credit_rx_buffer_if
// Link-side and consumer-side signals of the credit-based receive buffer.
//   datain    [DATA_W]  incoming flit from the upstream link
//   in_valid            flit on datain is valid this cycle (no backpressure)
//   co                  credit return pulse, one per dequeued flit
//   dataout   [DATA_W]  head-of-FIFO flit (first-word fall-through)
//   out_valid           buffer non-empty
//   out_ready           consumer accepts dataout this cycle
//   occupancy [PTR_W+1] number of stored flits, 0..DEPTH
//   overflow            sticky: a flit arrived while full with no pop
// Optional (CREDIT_RX_STATS_EN defined):
//   rx_count  [16]      accepted pushes, saturating
//   drop_count[8]       dropped flits, saturating
// master: upstream sender / consumer side. slave: the buffer.
// ---------------------------------------------------------------------------
interface credit_rx_buffer_if #(
  parameter int DATA_W = 20,
  parameter int PTR_W  = 2
);
  logic [DATA_W-1:0] datain;
  logic              in_valid;
  logic              co;
  logic [DATA_W-1:0] dataout;
  logic              out_valid;
  logic              out_ready;
  logic [PTR_W:0]    occupancy;
  logic              overflow;
`ifdef CREDIT_RX_STATS_EN
  logic [15:0]       rx_count;
  logic [7:0]        drop_count;
`endif

  modport master (
    output datain, in_valid, out_ready,
    input  co, dataout, out_valid, occupancy, overflow
`ifdef CREDIT_RX_STATS_EN
    , input rx_count, drop_count
`endif
  );

  modport slave (
    input  datain, in_valid, out_ready,
    output co, dataout, out_valid, occupancy, overflow
`ifdef CREDIT_RX_STATS_EN
    , output rx_count, drop_count
`endif
  );
endinterface

// File: rtl/credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// credit_rx_buffer
// Receive-side DEPTH-entry FIFO for one NoC link, downstream end of the
// credit flow control. Every dequeued flit returns one registered credit
// pulse on co, so the sender's credit counter tracks free buffer slots.
// Ports:
//   clk   clock, rising edge
//   RST   asynchronous active-high reset
//   link  credit_rx_buffer_if.slave (datain/in_valid in, dataout/out_valid/
//         out_ready consumer handshake, co, occupancy, overflow)
// Optional feature macro: CREDIT_RX_STATS_EN adds saturating rx_count and
// drop_count statistics to the interface.
// ---------------------------------------------------------------------------
module credit_rx_buffer #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic clk,
  input  logic RST,
  credit_rx_buffer_if.slave link
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic              co_q,     co_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, drop, full, empty;

`ifdef CREDIT_RX_STATS_EN
  logic [15:0] rx_cnt_q,   rx_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // out_ready is meaningless while empty.
  assign pop   = !empty && link.out_ready;
  // A pop in the same cycle frees the slot the incoming flit needs.
  assign push  = link.in_valid && (!full || pop);
  assign drop  = link.in_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    co_d       = pop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (drop) overflow_d = 1'b1;
  end

`ifdef CREDIT_RX_STATS_EN
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push) rx_cnt_d   = sat_inc16(rx_cnt_q);
    if (drop) drop_cnt_d = sat_inc8(drop_cnt_q);
  end
`endif

  // Control state: reset cancels stored flits and any pending credit pulse.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      co_q       <= 1'b0;
      overflow_q <= 1'b0;
`ifdef CREDIT_RX_STATS_EN
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      co_q       <= co_d;
      overflow_q <= overflow_d;
`ifdef CREDIT_RX_STATS_EN
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // Flit storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= link.datain;
  end

  // Gate the head read so stale memory never shows while empty.
  assign link.dataout   = empty ? '0 : mem_q[rd_ptr_q];
  assign link.out_valid = !empty;
  assign link.occupancy = count_q;
  assign link.co        = co_q;
  assign link.overflow  = overflow_q;
`ifdef CREDIT_RX_STATS_EN
  assign link.rx_count   = rx_cnt_q;
  assign link.drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_credit_rx_buffer
// Directed bench for credit_rx_buffer with a queue-based reference model
// checked every negative clock edge, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_credit_rx_buffer;

  localparam int DATA_W = 20;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  credit_rx_buffer_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) link();

  credit_rx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .RST (RST),
    .link(link)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored flits plus flags.
  logic [DATA_W-1:0] mq[$];
  bit                co_m  = 1'b0;
  bit                ovf_m = 1'b0;
  int                rx_m  = 0;
  int                drop_m = 0;

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      mq.delete();
      co_m   = 1'b0;
      ovf_m  = 1'b0;
      rx_m   = 0;
      drop_m = 0;
    end else begin
      bit pop_m, push_m;
      pop_m  = (mq.size() > 0) && (link.out_ready === 1'b1);
      push_m = (link.in_valid === 1'b1) && ((mq.size() < DEPTH) || pop_m);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back(link.datain);
        if (rx_m < 65535) rx_m++;
      end
      if ((link.in_valid === 1'b1) && !push_m) begin
        ovf_m = 1'b1;
        if (drop_m < 255) drop_m++;
      end
      co_m = pop_m;
    end
  end

  // Consumer-side capture of every handshake, plus per-cycle model compare.
  logic [DATA_W-1:0] got_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid", link.out_valid, (mq.size() != 0));
      check("m_occupancy", link.occupancy, mq.size());
      check("m_dataout",   link.dataout, (mq.size() != 0) ? mq[0] : '0);
      check("m_co",        link.co, co_m);
      check("m_overflow",  link.overflow, ovf_m);
`ifdef CREDIT_RX_STATS_EN
      check("m_rx_count",   link.rx_count, rx_m);
      check("m_drop_count", link.drop_count, drop_m);
`endif
      if (link.out_valid && link.out_ready) got_q.push_back(link.dataout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, release mid-cycle, realign to edge+1.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    #10;
    RST = 1'b0;
    step();
  endtask

  initial begin
    int credits, sent, cyc;
    link.datain    = '0;
    link.in_valid  = 1'b0;
    link.out_ready = 1'b0;
    #1 RST = 1'b1;
    #11 RST = 1'b0;
    step();
    chk_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      check("idle_co",        link.co, 1'b0);
      check("idle_out_valid", link.out_valid, 1'b0);
      check("idle_occupancy", link.occupancy, 0);
      check("idle_overflow",  link.overflow, 1'b0);
      step();
    end

    // Single flit, then one pop.
    link.in_valid = 1'b1;
    link.datain   = 20'h12345;
    step();
    link.in_valid = 1'b0;
    check("one_out_valid", link.out_valid, 1'b1);
    check("one_dataout",   link.dataout, 20'h12345);
    check("one_occupancy", link.occupancy, 1);
    link.out_ready = 1'b1;
    step();
    link.out_ready = 1'b0;
    check("one_co",        link.co, 1'b1);
    check("one_occ_after", link.occupancy, 0);
    step();
    check("one_co_clear",  link.co, 1'b0);

    // Fill to full, then one dropped flit.
    for (int i = 1; i <= 4; i++) begin
      link.in_valid = 1'b1;
      link.datain   = DATA_W'(i);
      step();
    end
    check("fill_occupancy", link.occupancy, 4);
    check("fill_overflow",  link.overflow, 1'b0);
    link.datain = 20'h00005;
    step();
    link.in_valid = 1'b0;
    check("drop_overflow",  link.overflow, 1'b1);
    check("drop_occupancy", link.occupancy, 4);
`ifdef CREDIT_RX_STATS_EN
    check("drop_rx_count",   link.rx_count, 5);
    check("drop_drop_count", link.drop_count, 1);
`endif
    link.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_dataout", link.dataout, DATA_W'(i));
      step();
      check("drain_co", link.co, 1'b1);
    end
    link.out_ready = 1'b0;
    check("drain_occupancy", link.occupancy, 0);
    step();
    check("drain_co_end",   link.co, 1'b0);
    check("drain_ovf_held", link.overflow, 1'b1);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      link.in_valid = 1'b1;
      link.datain   = DATA_W'(32'h10 + i);
      step();
    end
    link.datain    = 20'hABCDE;
    link.out_ready = 1'b1;
    step();
    link.in_valid = 1'b0;
    check("fullpp_occupancy", link.occupancy, 4);
    check("fullpp_overflow",  link.overflow, 1'b0);
    check("fullpp_co",        link.co, 1'b1);
    got_q.delete();
    for (int i = 0; i < 4; i++) step();
    link.out_ready = 1'b0;
    check("fullpp_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("fullpp_1",    got_q[0], 20'h00011);
      check("fullpp_last", got_q[3], 20'hABCDE);
    end

    // Streaming against a sender holding DEPTH credits.
    do_reset();
    got_q.delete();
    credits = DEPTH;
    sent = 0;
    cyc = 0;
    link.out_ready = 1'b1;
    while (!(sent == 12 && credits == DEPTH) && cyc < 200) begin
      if (sent < 12 && credits > 0) begin
        link.in_valid = 1'b1;
        link.datain   = DATA_W'(32'h5A000 + sent);
        credits--;
        sent++;
      end else begin
        link.in_valid = 1'b0;
      end
      step();
      if (link.co) credits++;
      cyc++;
    end
    link.in_valid  = 1'b0;
    link.out_ready = 1'b0;
    check("stream_timeout", (cyc < 200), 1'b1);
    check("stream_credits", credits, DEPTH);
    check("stream_overflow", link.overflow, 1'b0);
    check("stream_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      check("stream_order", got_q[i], DATA_W'(32'h5A000 + i));

    // Reset with three stored flits and a credit pulse pending.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      link.in_valid = 1'b1;
      link.datain   = DATA_W'(32'h300 + i);
      step();
    end
    link.in_valid  = 1'b0;
    link.out_ready = 1'b1;
    step();
    link.out_ready = 1'b0;
    check("pre_rst_co",        link.co, 1'b1);
    check("pre_rst_occupancy", link.occupancy, 3);
    #2;
    RST = 1'b1;
    #1;
    check("rst_out_valid", link.out_valid, 1'b0);
    check("rst_occupancy", link.occupancy, 0);
    check("rst_co",        link.co, 1'b0);
    check("rst_dataout",   link.dataout, 0);
    check("rst_overflow",  link.overflow, 1'b0);
`ifdef CREDIT_RX_STATS_EN
    check("rst_rx_count",   link.rx_count, 0);
    check("rst_drop_count", link.drop_count, 0);
`endif
    #9;
    RST = 1'b0;
    step();
    step();
    check("post_rst_occupancy", link.occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
